// File: rtl/lsb.sv
// Load/store buffer: in-order memory execution queue with RS/LSB result snooping.
// state | meaning
// IDLE  | no memory op outstanding
// WAIT  | head op issued, waiting for mem_done
// DRAIN | op was flushed while in flight; finish it with no broadcast
module lsb #(
  parameter int LSB_W = 3,
  parameter int ROB_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rob_clear,
  input  logic [ROB_W-1:0] rob_head_id,
  input  logic             lsb_ins,
  input  logic             lsb_is_store,
  input  logic [2:0]       lsb_funct3,
  input  logic [31:0]      lsb_imm,
  input  logic [ROB_W-1:0] lsb_ins_rob_id,
  input  logic             lsb_q1_busy,
  input  logic             lsb_q2_busy,
  input  logic [ROB_W-1:0] lsb_q1,
  input  logic [ROB_W-1:0] lsb_q2,
  input  logic [31:0]      lsb_v1,
  input  logic [31:0]      lsb_v2,
  input  logic             rs_has_output,
  input  logic [ROB_W-1:0] rs_rob_id,
  input  logic [31:0]      rs_output,
  output logic             lsb_full,
  output logic             lsb_has_output,
  output logic [ROB_W-1:0] lsb_rob_id,
  output logic [31:0]      lsb_output,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [31:0]      mem_addr,
  output logic [1:0]       mem_len,
  output logic [31:0]      mem_wdata,
  input  logic             mem_done,
  input  logic [31:0]      mem_rdata
);
  localparam int DEPTH = 1 << LSB_W;
  localparam int CNT_W = LSB_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_e;

  logic             busy_q [DEPTH];
  logic             st_q   [DEPTH];
  logic [2:0]       f3_q   [DEPTH];
  logic [31:0]      imm_q  [DEPTH];
  logic [ROB_W-1:0] rob_q  [DEPTH];
  logic [31:0]      v1_q   [DEPTH];
  logic [31:0]      v2_q   [DEPTH];
  logic             q1b_q  [DEPTH];
  logic             q2b_q  [DEPTH];
  logic [ROB_W-1:0] q1_q   [DEPTH];
  logic [ROB_W-1:0] q2_q   [DEPTH];

  logic [LSB_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  state_e           state_q;

  logic             has_out_q, mem_req_q, mem_wr_q;
  logic [ROB_W-1:0] rob_out_q;
  logic [31:0]      out_q, addr_q, wdata_q;
  logic [1:0]       len_q;

  logic             head_ready_d, push_d, pop_d, in1_busy_d, in2_busy_d;
  logic [31:0]      addr_d, result_d, in1_val_d, in2_val_d;
  logic [1:0]       len_d;

  assign lsb_full       = count_q >= CNT_W'(DEPTH - 1);
  assign lsb_has_output = has_out_q;
  assign lsb_rob_id     = rob_out_q;
  assign lsb_output     = out_q;
  assign mem_req        = mem_req_q;
  assign mem_wr         = mem_wr_q;
  assign mem_addr       = addr_q;
  assign mem_len        = len_q;
  assign mem_wdata      = wdata_q;

  always_comb begin
    head_ready_d = busy_q[head_q] && !q1b_q[head_q] &&
                   (!st_q[head_q] || (!q2b_q[head_q] && rob_head_id == rob_q[head_q]));
    addr_d = v1_q[head_q] + imm_q[head_q];
    case (f3_q[head_q])
      3'b000, 3'b100: len_d = 2'd0;
      3'b001, 3'b101: len_d = 2'd1;
      default:        len_d = 2'd2;
    endcase
    case (f3_q[head_q])
      3'b000:  result_d = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  result_d = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  result_d = {24'd0, mem_rdata[7:0]};
      3'b101:  result_d = {16'd0, mem_rdata[15:0]};
      default: result_d = mem_rdata;
    endcase
    if (st_q[head_q]) result_d = 32'd0;
    push_d = lsb_ins && (count_q != CNT_W'(DEPTH));
    pop_d  = (state_q == S_WAIT) && mem_done;
    // Same-cycle bypass so a dispatched operand never misses its broadcast
    in1_busy_d = lsb_q1_busy;
    in1_val_d  = lsb_v1;
    if (lsb_q1_busy && rs_has_output && rs_rob_id == lsb_q1) begin
      in1_busy_d = 1'b0;
      in1_val_d  = rs_output;
    end else if (lsb_q1_busy && has_out_q && rob_out_q == lsb_q1) begin
      in1_busy_d = 1'b0;
      in1_val_d  = out_q;
    end
    in2_busy_d = lsb_q2_busy;
    in2_val_d  = lsb_v2;
    if (lsb_q2_busy && rs_has_output && rs_rob_id == lsb_q2) begin
      in2_busy_d = 1'b0;
      in2_val_d  = rs_output;
    end else if (lsb_q2_busy && has_out_q && rob_out_q == lsb_q2) begin
      in2_busy_d = 1'b0;
      in2_val_d  = out_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i] <= 1'b0;
        q1b_q[i]  <= 1'b0;
        q2b_q[i]  <= 1'b0;
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      has_out_q <= 1'b0;
      rob_out_q <= '0;
      out_q     <= '0;
      mem_req_q <= 1'b0;
      mem_wr_q  <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        for (int i = 0; i < DEPTH; i++) busy_q[i] <= 1'b0;
        head_q    <= '0;
        tail_q    <= '0;
        count_q   <= '0;
        has_out_q <= 1'b0;
        // An issued op keeps its request stable; a store still reaches memory
        if (state_q != S_IDLE && !mem_done) begin
          state_q <= S_DRAIN;
        end else begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
        end
      end else begin
        has_out_q <= 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          if (busy_q[i] && q1b_q[i]) begin
            if (rs_has_output && rs_rob_id == q1_q[i]) begin
              q1b_q[i] <= 1'b0;
              v1_q[i]  <= rs_output;
            end else if (has_out_q && rob_out_q == q1_q[i]) begin
              q1b_q[i] <= 1'b0;
              v1_q[i]  <= out_q;
            end
          end
          if (busy_q[i] && q2b_q[i]) begin
            if (rs_has_output && rs_rob_id == q2_q[i]) begin
              q2b_q[i] <= 1'b0;
              v2_q[i]  <= rs_output;
            end else if (has_out_q && rob_out_q == q2_q[i]) begin
              q2b_q[i] <= 1'b0;
              v2_q[i]  <= out_q;
            end
          end
        end
        if (push_d) begin
          busy_q[tail_q] <= 1'b1;
          st_q[tail_q]   <= lsb_is_store;
          f3_q[tail_q]   <= lsb_funct3;
          imm_q[tail_q]  <= lsb_imm;
          rob_q[tail_q]  <= lsb_ins_rob_id;
          v1_q[tail_q]   <= in1_val_d;
          v2_q[tail_q]   <= in2_val_d;
          q1b_q[tail_q]  <= in1_busy_d;
          q2b_q[tail_q]  <= in2_busy_d;
          q1_q[tail_q]   <= lsb_q1;
          q2_q[tail_q]   <= lsb_q2;
          tail_q         <= tail_q + LSB_W'(1);
        end
        count_q <= count_q + CNT_W'(push_d) - CNT_W'(pop_d);
        case (state_q)
          S_IDLE: begin
            if (head_ready_d) begin
              mem_req_q <= 1'b1;
              mem_wr_q  <= st_q[head_q];
              addr_q    <= addr_d;
              len_q     <= len_d;
              wdata_q   <= v2_q[head_q];
              state_q   <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (mem_done) begin
              mem_req_q      <= 1'b0;
              has_out_q      <= 1'b1;
              rob_out_q      <= rob_q[head_q];
              out_q          <= result_d;
              busy_q[head_q] <= 1'b0;
              head_q         <= head_q + LSB_W'(1);
              state_q        <= S_IDLE;
            end
          end
          default: begin
            if (mem_done) begin
              mem_req_q <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lsb.sv
// Directed self-checking bench for the load/store buffer.
module tb_lsb;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1, rdy_in = 1'b1, rob_clear = 1'b0;
  logic [3:0]  rob_head_id = '0;
  logic        lsb_ins = 1'b0, lsb_is_store = 1'b0;
  logic [2:0]  lsb_funct3 = '0;
  logic [31:0] lsb_imm = '0;
  logic [3:0]  lsb_ins_rob_id = '0;
  logic        lsb_q1_busy = 1'b0, lsb_q2_busy = 1'b0;
  logic [3:0]  lsb_q1 = '0, lsb_q2 = '0;
  logic [31:0] lsb_v1 = '0, lsb_v2 = '0;
  logic        rs_has_output = 1'b0;
  logic [3:0]  rs_rob_id = '0;
  logic [31:0] rs_output = '0;
  logic        lsb_full, lsb_has_output, mem_req, mem_wr;
  logic [3:0]  lsb_rob_id;
  logic [31:0] lsb_output, mem_addr, mem_wdata;
  logic [1:0]  mem_len;
  logic        mem_done = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  lsb #(.LSB_W(3), .ROB_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .rob_head_id(rob_head_id), .lsb_ins(lsb_ins), .lsb_is_store(lsb_is_store),
    .lsb_funct3(lsb_funct3), .lsb_imm(lsb_imm), .lsb_ins_rob_id(lsb_ins_rob_id),
    .lsb_q1_busy(lsb_q1_busy), .lsb_q2_busy(lsb_q2_busy), .lsb_q1(lsb_q1),
    .lsb_q2(lsb_q2), .lsb_v1(lsb_v1), .lsb_v2(lsb_v2),
    .rs_has_output(rs_has_output), .rs_rob_id(rs_rob_id), .rs_output(rs_output),
    .lsb_full(lsb_full), .lsb_has_output(lsb_has_output), .lsb_rob_id(lsb_rob_id),
    .lsb_output(lsb_output), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_len(mem_len), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic dispatch(input logic st, input logic [2:0] f3, input logic [31:0] imm,
                          input logic [3:0] tag, input logic q1b, input logic [3:0] q1,
                          input logic [31:0] v1, input logic [31:0] v2);
    lsb_ins = 1'b1; lsb_is_store = st; lsb_funct3 = f3; lsb_imm = imm;
    lsb_ins_rob_id = tag; lsb_q1_busy = q1b; lsb_q1 = q1; lsb_v1 = v1; lsb_v2 = v2;
    tick();
    lsb_ins = 1'b0; lsb_q1_busy = 1'b0;
  endtask

  task automatic wait_req(input int budget, output bit ok);
    int n = 0;
    ok = mem_req;
    while (!ok && n < budget) begin
      tick();
      n++;
      ok = mem_req;
    end
  endtask

  task automatic do_mem(input logic [31:0] rdata);
    mem_done = 1'b1; mem_rdata = rdata;
    tick();
    mem_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    tick(); tick();
    checks++;
    if ({lsb_full, lsb_has_output, lsb_rob_id, lsb_output, mem_req, mem_wr,
         mem_addr, mem_len, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got full=%b out=%b req=%b addr=%h exp all zero",
               lsb_full, lsb_has_output, mem_req, mem_addr);
    end
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
    logic [31:0] rd   [6] = '{32'h80, 32'h80, 32'h8001, 32'h8001, 32'h12345678, 32'h9ABCDEF0};
    logic [31:0] expv [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001,
                              32'h12345678, 32'h9ABCDEF0};
    logic [1:0]  expl [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    for (int i = 0; i < 6; i++) begin
      dispatch(1'b0, f3[i], 32'hFFFFFFFC, 4'(i + 1), 1'b0, 4'd0, 32'h100, 32'd0);
      tick();
      checks++;
      if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'hFC || mem_len !== expl[i]) begin
        failures++;
        $display("FAIL load_issue[%0d] got req=%b wr=%b addr=%h len=%0d exp 1 0 000000fc %0d",
                 i, mem_req, mem_wr, mem_addr, mem_len, expl[i]);
      end
      do_mem(rd[i]);
      checks++;
      if (lsb_has_output !== 1'b1 || lsb_rob_id !== 4'(i + 1) || lsb_output !== expv[i]) begin
        failures++;
        $display("FAIL load_result[%0d] got v=%b tag=%0d data=%h exp 1 %0d %h",
                 i, lsb_has_output, lsb_rob_id, lsb_output, i + 1, expv[i]);
      end
      tick();
      checks++;
      if (lsb_has_output !== 1'b0 || mem_req !== 1'b0) begin
        failures++;
        $display("FAIL load_pulse[%0d] got out=%b req=%b exp 0 0", i, lsb_has_output, mem_req);
      end
    end
  endtask

  task automatic test_store_gating();
    bit seen = 0;
    rob_head_id = 4'd3;
    dispatch(1'b1, 3'b010, 32'd8, 4'd5, 1'b0, 4'd0, 32'h40, 32'hDEADBEEF);
    for (int i = 0; i < 10; i++) begin
      if (mem_req) seen = 1;
      tick();
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL store_gate got req_seen=1 exp 0");
    end
    rob_head_id = 4'd5;
    tick(); tick();
    checks++;
    if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 32'h48 ||
        mem_wdata !== 32'hDEADBEEF || mem_len !== 2'd2) begin
      failures++;
      $display("FAIL store_issue got req=%b wr=%b addr=%h wdata=%h len=%0d exp 1 1 00000048 deadbeef 2",
               mem_req, mem_wr, mem_addr, mem_wdata, mem_len);
    end
    do_mem(32'h5555AAAA);
    checks++;
    if (lsb_has_output !== 1'b1 || lsb_rob_id !== 4'd5 || lsb_output !== 32'd0) begin
      failures++;
      $display("FAIL store_result got v=%b tag=%0d data=%h exp 1 5 0",
               lsb_has_output, lsb_rob_id, lsb_output);
    end
    rob_head_id = 4'd0;
    tick();
  endtask

  task automatic test_dependency();
    bit ok;
    dispatch(1'b0, 3'b010, 32'h10, 4'd6, 1'b1, 4'd2, 32'h0, 32'd0);
    tick(); tick();
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL dep_hold got req=%b exp 0", mem_req);
    end
    rs_has_output = 1'b1; rs_rob_id = 4'd2; rs_output = 32'h2000;
    tick();
    rs_has_output = 1'b0;
    wait_req(4, ok);
    checks++;
    if (!ok || mem_addr !== 32'h2010) begin
      failures++;
      $display("FAIL dep_snoop got req=%b addr=%h exp 1 00002010", ok, mem_addr);
    end
    do_mem(32'h0BADF00D);
    checks++;
    if (lsb_has_output !== 1'b1 || lsb_rob_id !== 4'd6 || lsb_output !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL dep_result got v=%b tag=%0d data=%h exp 1 6 0badf00d",
               lsb_has_output, lsb_rob_id, lsb_output);
    end
    tick();
    rs_has_output = 1'b1; rs_rob_id = 4'd2; rs_output = 32'h3000;
    dispatch(1'b0, 3'b010, 32'h10, 4'd6, 1'b1, 4'd2, 32'h0, 32'd0);
    rs_has_output = 1'b0;
    wait_req(4, ok);
    checks++;
    if (!ok || mem_addr !== 32'h3010) begin
      failures++;
      $display("FAIL dep_bypass got req=%b addr=%h exp 1 00003010", ok, mem_addr);
    end
    do_mem(32'h1);
    tick();
    // Load B takes its base from load A's own result broadcast
    dispatch(1'b0, 3'b010, 32'h0, 4'd7, 1'b0, 4'd0, 32'h80, 32'd0);
    dispatch(1'b0, 3'b010, 32'h4, 4'd8, 1'b1, 4'd7, 32'h0, 32'd0);
    wait_req(4, ok);
    do_mem(32'h500);
    wait_req(4, ok);
    checks++;
    if (!ok || mem_addr !== 32'h504) begin
      failures++;
      $display("FAIL dep_lsb_bus got req=%b addr=%h exp 1 00000504", ok, mem_addr);
    end
    do_mem(32'h2);
    tick();
  endtask

  task automatic test_full_wrap();
    bit ok;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) begin
        checks++;
        if (lsb_full !== 1'b0) begin
          failures++;
          $display("FAIL full_early got %b exp 0 after 6", lsb_full);
        end
      end
      dispatch(1'b0, 3'b010, 32'd0, 4'(i), 1'b1, 4'(i + 8), 32'd0, 32'd0);
    end
    checks++;
    if (lsb_full !== 1'b1) begin
      failures++;
      $display("FAIL full_after7 got %b exp 1", lsb_full);
    end
    for (int i = 0; i < 7; i++) begin
      rs_has_output = 1'b1; rs_rob_id = 4'(i + 8); rs_output = 32'h1000 * (i + 1);
      tick();
    end
    rs_has_output = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wait_req(4, ok);
      checks++;
      if (!ok || mem_addr !== 32'h1000 * (i + 1)) begin
        failures++;
        $display("FAIL order_addr[%0d] got req=%b addr=%h exp 1 %h", i, ok, mem_addr, 32'h1000 * (i + 1));
      end
      do_mem(32'hA0000000 + i);
      checks++;
      if (lsb_has_output !== 1'b1 || lsb_rob_id !== 4'(i) || lsb_output !== 32'hA0000000 + i) begin
        failures++;
        $display("FAIL order_result[%0d] got tag=%0d data=%h exp %0d %h",
                 i, lsb_rob_id, lsb_output, i, 32'hA0000000 + i);
      end
    end
    for (int j = 0; j < 20; j++) begin
      dispatch(1'b0, 3'b010, 32'd4, 4'(j), 1'b0, 4'd0, 32'(j * 16), 32'd0);
      wait_req(4, ok);
      checks++;
      if (!ok || mem_addr !== 32'(j * 16 + 4)) begin
        failures++;
        $display("FAIL wrap_addr[%0d] got req=%b addr=%h exp 1 %h", j, ok, mem_addr, 32'(j * 16 + 4));
      end
      do_mem(32'h5A5A0000 ^ 32'(j));
      checks++;
      if (lsb_has_output !== 1'b1 || lsb_rob_id !== 4'(j) || lsb_output !== (32'h5A5A0000 ^ 32'(j))) begin
        failures++;
        $display("FAIL wrap_result[%0d] got tag=%0d data=%h exp %0d %h",
                 j, lsb_rob_id, lsb_output, j % 16, 32'h5A5A0000 ^ 32'(j));
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    dispatch(1'b0, 3'b010, 32'd0, 4'd10, 1'b0, 4'd0, 32'h600, 32'd0);
    wait_req(4, ok);
    mem_done = 1'b1; mem_rdata = 32'h11;
    lsb_ins = 1'b1; lsb_is_store = 1'b0; lsb_funct3 = 3'b010; lsb_imm = 32'd0;
    lsb_ins_rob_id = 4'd11; lsb_q1_busy = 1'b0; lsb_v1 = 32'h700;
    tick();
    mem_done = 1'b0; lsb_ins = 1'b0;
    checks++;
    if (!ok || lsb_has_output !== 1'b1 || lsb_rob_id !== 4'd10 || lsb_output !== 32'h11) begin
      failures++;
      $display("FAIL b2b_first got v=%b tag=%0d data=%h exp 1 10 00000011",
               lsb_has_output, lsb_rob_id, lsb_output);
    end
    wait_req(4, ok);
    checks++;
    if (!ok || mem_addr !== 32'h700) begin
      failures++;
      $display("FAIL b2b_second_addr got req=%b addr=%h exp 1 00000700", ok, mem_addr);
    end
    do_mem(32'h22);
    checks++;
    if (lsb_rob_id !== 4'd11 || lsb_output !== 32'h22 || lsb_full !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second got tag=%0d data=%h full=%b exp 11 00000022 0",
               lsb_rob_id, lsb_output, lsb_full);
    end
    tick();
  endtask

  task automatic test_flush();
    bit ok;
    bit bad = 0;
    dispatch(1'b0, 3'b010, 32'd0, 4'd3, 1'b0, 4'd0, 32'h200, 32'd0);
    dispatch(1'b0, 3'b010, 32'd0, 4'd4, 1'b0, 4'd0, 32'h204, 32'd0);
    wait_req(4, ok);
    rob_clear = 1'b1;
    tick();
    rob_clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (mem_req !== 1'b1 || mem_addr !== 32'h200 || lsb_has_output !== 1'b0) bad = 1;
      tick();
    end
    checks++;
    if (!ok || bad) begin
      failures++;
      $display("FAIL flush_drain got req=%b addr=%h out=%b exp held 1 00000200 0",
               mem_req, mem_addr, lsb_has_output);
    end
    do_mem(32'hAA);
    checks++;
    if (mem_req !== 1'b0 || lsb_has_output !== 1'b0) begin
      failures++;
      $display("FAIL flush_done got req=%b out=%b exp 0 0", mem_req, lsb_has_output);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req !== 1'b0 || lsb_has_output !== 1'b0) bad = 1;
      tick();
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL flush_empty got req=%b out=%b exp flushed entry never issued", mem_req, lsb_has_output);
    end
    rob_clear = 1'b1;
    dispatch(1'b0, 3'b010, 32'd0, 4'd12, 1'b0, 4'd0, 32'h280, 32'd0);
    rob_clear = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req !== 1'b0) bad = 1;
      tick();
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL flush_drops_dispatch got req=1 exp 0");
    end
    dispatch(1'b0, 3'b010, 32'd0, 4'd9, 1'b0, 4'd0, 32'h300, 32'd0);
    wait_req(4, ok);
    checks++;
    if (!ok || mem_addr !== 32'h300) begin
      failures++;
      $display("FAIL flush_resume_addr got req=%b addr=%h exp 1 00000300", ok, mem_addr);
    end
    do_mem(32'h77);
    checks++;
    if (lsb_has_output !== 1'b1 || lsb_rob_id !== 4'd9 || lsb_output !== 32'h77) begin
      failures++;
      $display("FAIL flush_resume_result got v=%b tag=%0d data=%h exp 1 9 00000077",
               lsb_has_output, lsb_rob_id, lsb_output);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    bit ok;
    dispatch(1'b0, 3'b010, 32'd0, 4'd13, 1'b0, 4'd0, 32'h400, 32'd0);
    dispatch(1'b0, 3'b010, 32'd0, 4'd14, 1'b0, 4'd0, 32'h404, 32'd0);
    wait_req(4, ok);
    rst_in = 1'b1;
    tick();
    checks++;
    if (!ok || {lsb_full, lsb_has_output, lsb_rob_id, lsb_output, mem_req, mem_wr,
                mem_addr, mem_len, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL mid_reset got full=%b out=%b req=%b addr=%h exp all zero",
               lsb_full, lsb_has_output, mem_req, mem_addr);
    end
    rst_in = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_empty got req=%b exp 0", mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_store_gating();
    test_dependency();
    test_full_wrap();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish exp finish before 500000");
    $fatal(1, "timeout");
  end
endmodule
